// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the mux_stream_arb block.
//   MODE_FIXED / MODE_RR : select-mode encoding carried on the mode signal.
//   get_slice()          : pulls one channel word out of a flattened channel bus.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bounds accepted by get_slice: the flattened bus (NCH*WIDTH) must fit
  // in BUS_MAX_W bits and one channel word in SLICE_MAX_W bits.
  localparam int unsigned SLICE_MAX_W = 64;
  localparam int unsigned BUS_MAX_W   = 1024;

  // Return channel idx of a flattened bus where each channel is 'width' bits
  // wide and channel k sits at bits [k*width +: width]. The caller truncates
  // the result to its own word width.
  function automatic logic [SLICE_MAX_W-1:0] get_slice(
    input logic [BUS_MAX_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          width
  );
    return SLICE_MAX_W'(bus >> (idx * width));
  endfunction

endpackage

// File: rtl/mux_stream_arb_if.sv
// mux_stream_arb_if: groups the producer-side and consumer-side stream signals
// of mux_stream_arb.
//   mode, sel            : select mode and fixed channel index
//   in_data/valid/ready  : NCH producer streams (channel k at [k*WIDTH +: WIDTH])
//   y/y_valid/y_ready    : merged consumer stream
//   y_ch                 : channel that produced the word held in y
// Modports: slave = the mux itself, master = the environment around it.
interface mux_stream_arb_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 8
);
  localparam int SELW = $clog2(NCH);

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     y;
  logic                 y_valid;
  logic                 y_ready;
  logic [SELW-1:0]      y_ch;

  modport master (
    output mode, sel, in_data, in_valid, y_ready,
    input  in_ready, y, y_valid, y_ch
  );

  modport slave (
    input  mode, sel, in_data, in_valid, y_ready,
    output in_ready, y, y_valid, y_ch
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority arbiter.
//   i_req     : request vector, one bit per channel
//   i_ptr     : last granted channel; search starts at i_ptr+1 and wraps mod NCH
//   i_en      : arbiter enable; no grant when low
//   o_gnt     : one-hot grant (all zero when nothing is granted)
//   o_gnt_idx : encoded index of the granted channel (0 when nothing is granted)
module rr_arbiter #(
  parameter  int NCH  = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  i_req,
  input  logic [SELW-1:0] i_ptr,
  input  logic            i_en,
  output logic [NCH-1:0]  o_gnt,
  output logic [SELW-1:0] o_gnt_idx
);

  int   w_pos;
  logic w_found;

  // Walk the channels in priority order ptr+1, ptr+2, ... and grant the first requester.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_pos     = 0;
    for (int i = 1; i <= NCH; i++) begin
      // Modulo keeps the position inside 0..NCH-1 even for non-power-of-2 NCH.
      w_pos = (int'(i_ptr) + i) % NCH;
      for (int k = 0; k < NCH; k++) begin
        if (i_en && !w_found && (w_pos == k) && i_req[k]) begin
          o_gnt[k]  = 1'b1;
          o_gnt_idx = SELW'(k);
          w_found   = 1'b1;
        end else begin
          o_gnt[k]  = o_gnt[k];
        end
      end
    end
  end

endmodule

// File: rtl/mux_stream_arb.sv
// mux_stream_arb: N-channel registered stream mux with fixed or round-robin select.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : mux_stream_arb_if.slave (mode, sel, in_* producer streams,
//             y/y_valid/y_ready consumer stream, y_ch source channel)
// A single output register holds one word; a new word is loaded whenever the
// register is empty or being drained this cycle, giving 1 word/cycle throughput.
module mux_stream_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 8,
  localparam int SELW  = $clog2(NCH)
) (
  input logic            i_clk,
  input logic            i_rst_n,
  mux_stream_arb_if.slave bus
);

  logic             w_load_en;
  logic             w_rr_en;
  logic             w_fix_ok;
  logic             w_gnt_any;
  logic [SELW-1:0]  w_gnt_idx;
  logic [NCH-1:0]   w_rr_gnt;
  logic [SELW-1:0]  w_rr_idx;
  logic [NCH-1:0]   w_in_ready;
  logic [WIDTH-1:0] w_y_next;

  logic [WIDTH-1:0] r_y;
  logic             r_y_valid;
  logic [SELW-1:0]  r_y_ch;
  logic [SELW-1:0]  r_rr_ptr;

  assign w_load_en = ~r_y_valid | bus.y_ready;
  assign w_rr_en   = (bus.mode == MODE_RR);

  rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
    .i_req     (bus.in_valid),
    .i_ptr     (r_rr_ptr),
    .i_en      (w_rr_en),
    .o_gnt     (w_rr_gnt),
    .o_gnt_idx (w_rr_idx)
  );

  // Fixed mode: Sel grants only if it names an existing channel that is valid;
  // Sel values >= NCH match no k and therefore never grant.
  always_comb begin
    w_fix_ok = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      w_fix_ok = w_fix_ok | ((SELW'(k) == bus.sel) & bus.in_valid[k]);
    end
  end

  // Choose between round-robin and fixed grant.
  always_comb begin
    if (w_rr_en) begin
      w_gnt_any = |w_rr_gnt;
      w_gnt_idx = w_rr_idx;
    end else begin
      w_gnt_any = w_fix_ok;
      w_gnt_idx = bus.sel;
    end
  end

  // Ready goes only to the granted channel, only when the output register can
  // load, and never while reset is asserted.
  always_comb begin
    w_in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      w_in_ready[k] = i_rst_n & w_load_en & w_gnt_any & (w_gnt_idx == SELW'(k));
    end
  end

  assign w_y_next = WIDTH'(get_slice(BUS_MAX_W'(bus.in_data), 32'(w_gnt_idx), 32'(WIDTH)));

  // Output register and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_y_ch    <= '0;
      r_rr_ptr  <= SELW'(NCH - 1);
    end else if (w_load_en) begin
      if (w_gnt_any) begin
        r_y       <= w_y_next;
        r_y_ch    <= w_gnt_idx;
        r_y_valid <= 1'b1;
        // Fixed-mode transfers must not disturb round-robin fairness.
        if (w_rr_en) begin
          r_rr_ptr <= w_gnt_idx;
        end
      end else begin
        // Nothing to load: y and y_ch keep their last values, only valid drops.
        r_y_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.y        = r_y;
  assign bus.y_valid  = r_y_valid;
  assign bus.y_ch     = r_y_ch;

endmodule
